// File: rtl/stream_trim_if.sv
// Handshake bundle for stream_trim: input beat stream and registered output beat stream.
// The slave modport is the trimmer's view, the master modport is the driver/sink's view.
interface stream_trim_if #(
  parameter int unsigned width_p = 8
) ();
  logic [width_p-1:0] data_i;
  logic               valid_i;
  logic               ready_o;
  logic               valid_o;
  logic [width_p-1:0] data_o;
  logic               last_o;
  logic               ready_i;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, valid_o, data_o, last_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, valid_o, data_o, last_o
  );
endinterface

// File: rtl/stream_trim.sv
// Strips the first trim_p beats of every frame_len_p-beat frame and re-times the rest through a
// 1-entry elastic output register. Define TRIM_ZERO_FILL_EN to emit trimmed beats as zeros instead.
module stream_trim #(
  parameter int unsigned width_p     = 8,
  parameter int unsigned trim_p      = 8,
  parameter int unsigned frame_len_p = 64
) (
  input  logic         clk_i,
  input  logic         reset_i,
  stream_trim_if.slave bus
);

  localparam int unsigned CntW = $clog2(frame_len_p + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(frame_len_p - 1);
  localparam logic [CntW-1:0] TrimEnd = CntW'((trim_p == 0) ? 0 : trim_p - 1);

  typedef enum logic [0:0] {StDrop, StPass} state_e;

  localparam state_e StReset = (trim_p > 0) ? StDrop : StPass;

  state_e state_q, state_d;

  logic [CntW-1:0]    cnt_q;
  logic               valid_q;
  logic [width_p-1:0] data_q;
  logic               last_q;

  logic               ready;
  logic               accept;
  logic               load;
  logic [width_p-1:0] load_data;
  logic               cnt_last;

  assign cnt_last = (cnt_q == LastCnt);
  assign accept   = bus.valid_i && ready;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDrop: if (accept && (cnt_q == TrimEnd)) state_d = StPass;
      StPass: if (accept && cnt_last) state_d = StReset;
      default: state_d = StReset;
    endcase
  end

  // Output/handshake logic
  always_comb begin
    ready     = bus.ready_i || !valid_q;
    load      = 1'b0;
    load_data = bus.data_i;
`ifdef TRIM_ZERO_FILL_EN
    load = accept;
    if (state_q == StDrop) load_data = '0;
`else
    // Trimmed beats never touch the output register, so they are always accepted.
    if (state_q == StDrop) ready = 1'b1;
    load = accept && (state_q == StPass);
`endif
  end

  // Beat counter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
    end
  end

  // Elastic output register: a load always wins, otherwise a consume empties it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
      last_q  <= cnt_last;
    end else if (bus.ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.last_o  = last_q;

endmodule

// File: tb/tb_stream_trim.sv
// Directed vector table for stream_trim (trim 2, frame 6) plus a randomized pass-through check
// of a trim_p=0 instance against an in-order scoreboard.
module tb_stream_trim;

  localparam int unsigned W = 8;
  localparam int unsigned T = 2;
  localparam int unsigned F = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stream_trim_if #(.width_p(W)) bus  ();
  stream_trim_if #(.width_p(W)) bus0 ();

  stream_trim #(.width_p(W), .trim_p(T), .frame_len_p(F)) u_dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  stream_trim #(.width_p(W), .trim_p(0), .frame_len_p(F)) u_dut0 (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus0)
  );

  typedef struct {
    logic         rst;
    logic         vi;
    logic [W-1:0] di;
    logic         ri;
    logic         ro;
    logic         vo;
    logic         chk;
    logic [W-1:0] dout;
    logic         lo;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void a(bit r, bit vi, int di, bit ri, bit ro, bit vo, bit chk, int d, bit l);
    vec_t v;
    v.rst = r; v.vi = vi; v.di = W'(di); v.ri = ri;
    v.ro = ro; v.vo = vo; v.chk = chk; v.dout = W'(d); v.lo = l;
    vecs.push_back(v);
  endfunction

  // Shorthands: idle-dropping beat with no output, and a beat seen while out=d is valid.
  function automatic void nv(int di);
    a(0, 1, di, 1, 1, 0, 0, 0, 0);
  endfunction

  function automatic void ov(int di, int d, bit l);
    a(0, di != 0, di, 1, 1, 1, 1, d, l);
  endfunction

  logic [W-1:0] q[$];
  logic [W-1:0] exp_d;
  logic         exp_l;
  int           n_in;
  int           n_out;
  int           cyc;

  initial begin
`ifndef TRIM_ZERO_FILL_EN
    // Frame 1..6, ready_i high; first vector also checks reset values.
    a(0, 1, 1, 1, 1, 0, 1, 0, 0);
    nv(2); nv(3); ov(4, 3, 0); ov(5, 4, 0); ov(6, 5, 0); ov(0, 6, 1);
    a(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Stall 3 cycles while 4 is held.
    nv(1); nv(2); nv(3); ov(4, 3, 0);
    a(0, 1, 5, 0, 0, 1, 1, 4, 0);
    a(0, 1, 5, 0, 0, 1, 1, 4, 0);
    a(0, 1, 5, 0, 0, 1, 1, 4, 0);
    ov(5, 4, 0); ov(6, 5, 0); ov(0, 6, 1);
    a(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Back-to-back frames; next frame's dropped beats overlap the stalled last beat.
    nv(1); nv(2); nv(3); ov(4, 3, 0); ov(5, 4, 0); ov(6, 5, 0);
    a(0, 1, 11, 0, 1, 1, 1, 6, 1);
    a(0, 1, 12, 0, 1, 1, 1, 6, 1);
    ov(13, 6, 1); ov(14, 13, 0); ov(15, 14, 0); ov(16, 15, 0); ov(0, 16, 1);
    a(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Reset after 4 beats, then a fresh frame with a bubble in the trim period.
    nv(1); nv(2); nv(3); ov(4, 3, 0);
    a(1, 0, 0, 0, 0, 1, 1, 4, 0);
    a(0, 1, 21, 1, 1, 0, 1, 0, 0);
    a(0, 0, 0, 1, 1, 0, 0, 0, 0);
    nv(22); nv(23); ov(24, 23, 0); ov(25, 24, 0); ov(26, 25, 0); ov(0, 26, 1);
    a(0, 0, 0, 1, 1, 0, 0, 0, 0);
`else
    // Zero-fill: trimmed beats come out as zeros; frame length unchanged.
    a(0, 1, 1, 1, 1, 0, 1, 0, 0);
    ov(2, 0, 0); ov(3, 0, 0); ov(4, 3, 0); ov(5, 4, 0); ov(6, 5, 0); ov(0, 6, 1);
    a(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Backpressure during the trim period now stalls the input.
    nv(1);
    a(0, 1, 2, 0, 0, 1, 1, 0, 0);
    ov(2, 0, 0); ov(3, 0, 0); ov(4, 3, 0); ov(5, 4, 0); ov(6, 5, 0); ov(0, 6, 1);
    a(0, 0, 0, 1, 1, 0, 0, 0, 0);
`endif

    rst = 1'b1;
    bus.valid_i = 1'b0; bus.data_i = '0; bus.ready_i = 1'b1;
    bus0.valid_i = 1'b0; bus0.data_i = '0; bus0.ready_i = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      bus.valid_i = vecs[i].vi;
      bus.data_i  = vecs[i].di;
      bus.ready_i = vecs[i].ri;
      #1;
      n_vec++;
      if (bus.ready_o !== vecs[i].ro || bus.valid_o !== vecs[i].vo ||
          (vecs[i].chk && (bus.data_o !== vecs[i].dout || bus.last_o !== vecs[i].lo))) begin
        n_bad++;
        $display("FAIL vec %0d: ready_o=%b valid_o=%b data_o=%0d last_o=%b, expected %b %b %0d %b%s",
                 i, bus.ready_o, bus.valid_o, bus.data_o, bus.last_o, vecs[i].ro, vecs[i].vo,
                 vecs[i].dout, vecs[i].lo, vecs[i].chk ? "" : " (data/last unchecked)");
      end
    end

    @(negedge clk);
    rst = 1'b0;
    bus.valid_i = 1'b0;

    // trim_p=0 instance: 3 frames of random traffic must come out unchanged, in order.
    n_in = 0; n_out = 0; cyc = 0;
    while (n_out < 3 * F && cyc < 600) begin
      @(negedge clk);
      cyc++;
      bus0.valid_i = (n_in < 3 * F) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus0.data_i  = W'($urandom);
      bus0.ready_i = 1'($urandom_range(0, 1));
      #1;
      if (bus0.valid_o && bus0.ready_i) begin
        n_vec++;
        exp_l = (n_out % F) == F - 1;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rand beat %0d: data_o=%0d with no beat outstanding", n_out, bus0.data_o);
        end else begin
          exp_d = q.pop_front();
          if (bus0.data_o !== exp_d || bus0.last_o !== exp_l) begin
            n_bad++;
            $display("FAIL rand beat %0d: data_o=%0d last_o=%b, expected %0d %b",
                     n_out, bus0.data_o, bus0.last_o, exp_d, exp_l);
          end
        end
        n_out++;
      end
      if (bus0.valid_i && bus0.ready_o) begin
        q.push_back(bus0.data_i);
        n_in++;
      end
    end
    n_vec++;
    if (n_out != 3 * F) begin
      n_bad++;
      $display("FAIL rand drain: %0d beats out, expected %0d", n_out, 3 * F);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
